// File: rtl/fpga_cfg_pkg.sv
// rtl/fpga_cfg_pkg.sv - shared types, constants and CRC helper for the config loader
// Purpose: loader FSM state encoding, CRC-8 polynomial and the one-bit CRC step.
// Ports: none (package).
package fpga_cfg_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [7:0] CRC8_POLY = 8'h07;

   // MSB-first CRC-8 update with one serial bit.
   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
      return {crc[6:0], 1'b0} ^ ((crc[7] ^ b) ? CRC8_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/fpga_cfg_loader_if.sv
// rtl/fpga_cfg_loader_if.sv - config byte stream interface (valid/ready)
// Purpose: carries config bytes from the upstream source into the loader.
// Signals: cfg_data (byte, bit 7 shifted first), cfg_valid (source has a byte),
//          cfg_ready (loader takes the byte this cycle).
// Modports: master = byte source, slave = loader.
interface fpga_cfg_loader_if;

   logic [7:0] cfg_data;
   logic       cfg_valid;
   logic       cfg_ready;

   modport master (output cfg_data, output cfg_valid, input cfg_ready);
   modport slave  (input cfg_data, input cfg_valid, output cfg_ready);

endinterface

// File: rtl/fpga_cfg_clkgen.sv
// rtl/fpga_cfg_clkgen.sv - prog_clk phase generator with rise/fall strobes
// Purpose: while run is high, prog_clk is low for HALF_DIV clk cycles then high
//          for HALF_DIV cycles. rise/fall are high in the cycle whose closing
//          clk edge drives prog_clk 0->1 / 1->0.
// Ports: clk, rst_n (async active-low), run (enable), clear (sync force low),
//        prog_clk (chain clock), rise, fall (combinational strobes).
module fpga_cfg_clkgen #(
   parameter int HALF_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic clear,
   output logic prog_clk,
   output logic rise,
   output logic fall
);

   localparam int PH_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_DIV - 1);

   logic [PH_W-1:0] ph_cnt;
   logic            ph_end;

   assign ph_end = run & (ph_cnt == PH_LAST);
   assign rise   = ph_end & ~prog_clk;
   assign fall   = ph_end & prog_clk;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph_cnt   <= '0;
         prog_clk <= 1'b0;
      end else if (clear || !run) begin
         // Idle phase always restarts at the beginning of a low half.
         ph_cnt   <= '0;
         prog_clk <= 1'b0;
      end else if (ph_end) begin
         ph_cnt   <= '0;
         prog_clk <= ~prog_clk;
      end else begin
         ph_cnt   <= ph_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/fpga_cfg_loader.sv
// rtl/fpga_cfg_loader.sv - bitstream loader driving the fabric configuration chain
// Purpose: takes config bytes over cfg (valid/ready), shifts them MSB-first onto
//          ccff_head with a generated prog_clk, runs CRC-8 over ccff_tail, and
//          holds the fabric in reset until exactly CHAIN_LEN bits are loaded.
// Ports: clk, rst_n (async active-low), start (pulse), abort (level),
//        cfg (byte stream, slave), prog_clk, ccff_head, ccff_tail (chain),
//        busy (LOAD/SHIFT), done (DONE), fab_rst_n (fabric reset), tail_crc.
module fpga_cfg_loader
   import fpga_cfg_pkg::*;
#(
   parameter int CHAIN_LEN = 256,
   parameter int HALF_DIV  = 2,
   parameter int CNT_W     = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
   fpga_cfg_loader_if.slave    cfg,
   output logic                prog_clk,
   output logic                ccff_head,
   input  logic                ccff_tail,
   output logic                busy,
   output logic                done,
   output logic                fab_rst_n,
   output logic [7:0]          tail_crc
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN);

   state_t           state, state_next;
   logic [7:0]       shreg;
   logic [2:0]       bit_idx;
   logic [CNT_W-1:0] bit_cnt;
   logic [7:0]       crc;
   logic             run, rise, fall, accept, load_start, chain_full;

   assign chain_full = (bit_cnt == LAST_CNT);
   assign accept     = cfg.cfg_valid & cfg.cfg_ready;

   fpga_cfg_clkgen #(.HALF_DIV(HALF_DIV)) u_clkgen (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (run),
      .clear    (abort),
      .prog_clk (prog_clk),
      .rise     (rise),
      .fall     (fall)
   );

   always_comb begin
      state_next    = state;
      cfg.cfg_ready = 1'b0;
      run           = 1'b0;
      load_start    = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_next = LOAD;
               load_start = 1'b1;
            end
         end
         LOAD: begin
            cfg.cfg_ready = 1'b1;
            if (cfg.cfg_valid) state_next = SHIFT;
         end
         SHIFT: begin
            run = 1'b1;
            // Leave SHIFT only at the end of a high phase, so prog_clk is already low.
            if (fall) begin
               if (chain_full)          state_next = DONE;
               else if (bit_idx == 3'd0) state_next = LOAD;
            end
         end
         default: state_next = IDLE;
      endcase
      if (abort) begin
         state_next = IDLE;
         load_start = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         shreg     <= 8'h00;
         bit_idx   <= 3'd0;
         bit_cnt   <= '0;
         crc       <= 8'h00;
         ccff_head <= 1'b0;
         fab_rst_n <= 1'b0;
      end else begin
         state     <= state_next;
         // Registered so the fabric reset is a clean flop output.
         fab_rst_n <= (state_next == DONE);
         if (abort) begin
            ccff_head <= 1'b0;
         end else begin
            if (load_start) begin
               bit_cnt <= '0;
               crc     <= 8'h00;
            end
            if (accept) begin
               shreg     <= cfg.cfg_data;
               bit_idx   <= 3'd7;
               ccff_head <= cfg.cfg_data[7];
            end
            if (rise) begin
               crc <= crc8_step(crc, ccff_tail);
               if (!chain_full) bit_cnt <= bit_cnt + 1'b1;
            end
            if (fall) begin
               // Next bit appears together with prog_clk going low; unused bits are dropped.
               shreg     <= {shreg[6:0], 1'b0};
               bit_idx   <= bit_idx - 1'b1;
               ccff_head <= (bit_idx == 3'd0 || chain_full) ? 1'b0 : shreg[6];
            end
         end
      end
   end

   assign busy     = (state == LOAD) || (state == SHIFT);
   assign done     = (state == DONE);
   assign tail_crc = crc;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// tb/tb_fpga_cfg_loader.sv - scoreboard bench for fpga_cfg_loader
module tb_fpga_cfg_loader;

   typedef struct {
      logic [15:0] chain;
      logic [7:0]  crc;
      int          lat;
      int          edges;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_run = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] crc_ref(input logic [15:0] v);
      logic [7:0] c = 8'h00;
      logic fb;
      for (int i = 15; i >= 0; i--) begin
         fb = c[7] ^ v[i];
         c = {c[6:0], 1'b0};
         if (fb) c = c ^ 8'h07;
      end
      return c;
   endfunction

   // DUT A: 16-bit chain
   logic a_start = 1'b0, a_abort = 1'b0;
   logic a_prog_clk, a_head, a_tail, a_busy, a_done, a_fab;
   logic [7:0] a_crc;
   fpga_cfg_loader_if ifa ();
   logic [15:0] chain_a = 16'h0000;
   int a_edges = 0;
   int a_t0 = 0;
   assign a_tail = chain_a[15];
   always @(posedge a_prog_clk) begin
      chain_a <= {chain_a[14:0], a_head};
      a_edges++;
   end

   fpga_cfg_loader #(.CHAIN_LEN(16), .HALF_DIV(2), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort), .cfg(ifa),
      .prog_clk(a_prog_clk), .ccff_head(a_head), .ccff_tail(a_tail),
      .busy(a_busy), .done(a_done), .fab_rst_n(a_fab), .tail_crc(a_crc)
   );

   // DUT B: 12-bit chain
   logic b_start = 1'b0, b_abort = 1'b0;
   logic b_prog_clk, b_head, b_tail, b_busy, b_done, b_fab;
   logic [7:0] b_crc;
   fpga_cfg_loader_if ifb ();
   logic [11:0] chain_b = 12'h000;
   int b_edges = 0;
   int b_t0 = 0;
   assign b_tail = chain_b[11];
   always @(posedge b_prog_clk) begin
      chain_b <= {chain_b[10:0], b_head};
      b_edges++;
   end

   fpga_cfg_loader #(.CHAIN_LEN(12), .HALF_DIV(2), .CNT_W(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort), .cfg(ifb),
      .prog_clk(b_prog_clk), .ccff_head(b_head), .ccff_tail(b_tail),
      .busy(b_busy), .done(b_done), .fab_rst_n(b_fab), .tail_crc(b_crc)
   );

   exp_t exp_a[$];
   exp_t exp_b[$];
   exp_t e_a, e_b;
   logic a_done_q = 1'b0, b_done_q = 1'b0;

   // Monitors: a rising done is the DUT presenting a finished load.
   always @(negedge clk) begin
      if (a_done && !a_done_q) begin
         if (exp_a.size() == 0) begin
            check("a_unexpected_done", 1, 0);
         end else begin
            e_a = exp_a.pop_front();
            check("a_chain", chain_a, e_a.chain);
            check("a_crc", a_crc, e_a.crc);
            check("a_fab_rst_n", a_fab, 1);
            check("a_edges", a_edges, e_a.edges);
            if (e_a.lat >= 0) check("a_latency", cyc - a_t0, e_a.lat);
         end
      end
      a_done_q = a_done;
   end

   always @(negedge clk) begin
      if (b_done && !b_done_q) begin
         if (exp_b.size() == 0) begin
            check("b_unexpected_done", 1, 0);
         end else begin
            e_b = exp_b.pop_front();
            check("b_chain", {4'h0, chain_b}, e_b.chain);
            check("b_crc", b_crc, e_b.crc);
            check("b_fab_rst_n", b_fab, 1);
            check("b_edges", b_edges, e_b.edges);
            if (e_b.lat >= 0) check("b_latency", cyc - b_t0, e_b.lat);
         end
      end
      b_done_q = b_done;
   end

   task automatic pulse_start(input bit sel);
      @(negedge clk);
      if (sel) b_start = 1'b1; else a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      b_start = 1'b0;
      if (sel) begin b_t0 = cyc; b_edges = 0; end
      else     begin a_t0 = cyc; a_edges = 0; end
   endtask

   task automatic send(input bit sel, input logic [7:0] d);
      bit ok = 1'b0;
      int k = 0;
      if (sel) begin ifb.cfg_data = d; ifb.cfg_valid = 1'b1; end
      else     begin ifa.cfg_data = d; ifa.cfg_valid = 1'b1; end
      while (!ok && k < 500) begin
         if (sel ? ifb.cfg_ready : ifa.cfg_ready) ok = 1'b1;
         else begin @(negedge clk); k++; end
      end
      if (ok) @(posedge clk);
      #1;
      ifa.cfg_valid = 1'b0;
      ifb.cfg_valid = 1'b0;
      check("send_accepted", ok, 1);
   endtask

   task automatic wait_done(input bit sel);
      int k = 0;
      while (!(sel ? b_done : a_done) && k < 3000) begin
         @(negedge clk);
         k++;
      end
      check("done_reached", sel ? b_done : a_done, 1);
      @(negedge clk);
   endtask

   task automatic wait_edges(input int n);
      int k = 0;
      while (a_edges < n && k < 500) begin
         @(negedge clk);
         k++;
      end
      check("edges_reached", a_edges, n);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi;
      int e0;
      int k;
      ifa.cfg_valid = 1'b0; ifa.cfg_data = 8'h00;
      ifb.cfg_valid = 1'b0; ifb.cfg_data = 8'h00;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ready", ifa.cfg_ready, 0);
      check("rst_prog_clk", a_prog_clk, 0);
      check("rst_head", a_head, 0);
      check("rst_busy", a_busy, 0);
      check("rst_done", a_done, 0);
      check("rst_fab", a_fab, 0);
      check("rst_crc", a_crc, 8'h00);
      check("rst_b_ready", ifb.cfg_ready, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 12-bit chain: 0xFF,0xF0 -> low nibble of 0xF0 dropped
      exp_b.push_back('{chain: 16'h0FFF, crc: 8'h00, lat: 50, edges: 12});
      pulse_start(1);
      send(1, 8'hFF);
      send(1, 8'hF0);
      wait_done(1);
      check("b_head_after_done", b_head, 0);
      check("b_busy_after_done", b_busy, 0);
      repeat (10) @(negedge clk);
      check("b_edges_hold", b_edges, 12);

      // First load into an all-zero chain
      exp_a.push_back('{chain: 16'hA53C, crc: 8'h00, lat: 66, edges: 16});
      pulse_start(0);
      send(0, 8'hA5);
      send(0, 8'h3C);
      wait_done(0);

      // Reload: tail returns A5,3C
      exp_a.push_back('{chain: 16'hA53C, crc: 8'hED, lat: 66, edges: 16});
      pulse_start(0);
      check("fab_drop_after_start", a_fab, 0);
      send(0, 8'hA5);
      send(0, 8'h3C);
      wait_done(0);

      // Upstream stall between bytes
      exp_a.push_back('{chain: 16'hA53C, crc: 8'hED, lat: -1, edges: 16});
      pulse_start(0);
      send(0, 8'hA5);
      k = 0;
      while (!ifa.cfg_ready && k < 200) begin @(negedge clk); k++; end
      check("gap_in_load", ifa.cfg_ready, 1);
      e0 = a_edges;
      hi = 0;
      repeat (10) begin
         if (a_prog_clk) hi++;
         @(negedge clk);
      end
      check("gap_edges", a_edges, e0);
      check("gap_prog_clk_high", hi, 0);
      check("gap_still_ready", ifa.cfg_ready, 1);
      send(0, 8'h3C);
      wait_done(0);

      // Abort after 5 bits
      pulse_start(0);
      send(0, 8'hA5);
      wait_edges(5);
      a_abort = 1'b1;
      @(negedge clk);
      a_abort = 1'b0;
      check("abort_prog_clk", a_prog_clk, 0);
      check("abort_busy", a_busy, 0);
      check("abort_done", a_done, 0);
      check("abort_fab", a_fab, 0);
      check("abort_head", a_head, 0);
      check("abort_ready", ifa.cfg_ready, 0);
      check("abort_crc_partial", a_crc, 8'h6C);
      check("abort_chain", chain_a, 16'hA794);
      repeat (6) @(negedge clk);
      check("abort_no_edges", a_edges, 5);

      exp_a.push_back('{chain: 16'hA53C, crc: crc_ref(16'hA794), lat: 66, edges: 16});
      pulse_start(0);
      send(0, 8'hA5);
      send(0, 8'h3C);
      wait_done(0);

      // start during SHIFT is ignored
      exp_a.push_back('{chain: 16'hA53C, crc: 8'hED, lat: 66, edges: 16});
      pulse_start(0);
      send(0, 8'hA5);
      wait_edges(3);
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      check("start_ignored_busy", a_busy, 1);
      send(0, 8'h3C);
      wait_done(0);

      // Async reset mid-SHIFT
      pulse_start(0);
      send(0, 8'hA5);
      wait_edges(3);
      check("pre_reset_prog_clk", a_prog_clk, 1);
      check("pre_reset_busy", a_busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_prog_clk", a_prog_clk, 0);
      check("arst_head", a_head, 0);
      check("arst_busy", a_busy, 0);
      check("arst_done", a_done, 0);
      check("arst_fab", a_fab, 0);
      check("arst_crc", a_crc, 8'h00);
      check("arst_ready", ifa.cfg_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("exp_a_drained", exp_a.size(), 0);
      check("exp_b_drained", exp_b.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
